// File: rtl/cpu_isa_pkg.sv
// ============================================================================
// Module   : cpu_isa_pkg
// Brief    : ISA opcode/funct encodings and fetch-stage state type, shared by
//            the fetch unit and the control unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

    // Flags any encoding the core does not implement.
    function automatic logic is_illegal(input logic [31:0] instr);
        logic r_type_ok;
        r_type_ok = (instr[5:0] == FN_ADD) || (instr[5:0] == FN_SUB) ||
                    (instr[5:0] == FN_AND) || (instr[5:0] == FN_OR)  ||
                    (instr[5:0] == FN_XOR) || (instr[5:0] == FN_NOR);
        case (instr[31:26])
            OP_RTYPE: return !r_type_ok;
            OP_LW, OP_SW, OP_BEQ, OP_ADDI: return 1'b0;
            default:  return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifu_fifo.sv
// ============================================================================
// Module   : ifu_fifo
// Brief    : Synchronous in-order FIFO with flush; output reads zero when empty.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int              PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W:0]  c_depth   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  c_cnt_one = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_full;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign empty     = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_pop_ok  = pop && !empty;
    // A full FIFO that pops this cycle still has room for the push.
    assign w_push_ok = push && (!w_full || w_pop_ok);
    assign count     = r_count;
    assign pop_data  = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + c_ptr_one;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : PC owner, credit-limited imem requester and instruction buffer
//            feeding decode; optional IFU_ILLEGAL_OPCODE_CHECK_EN adds if_illegal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import cpu_isa_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [5:0]        if_opcode,
    output logic [5:0]        if_funct
`ifdef IFU_ILLEGAL_OPCODE_CHECK_EN
    ,
    output logic              if_illegal
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef IFU_ILLEGAL_OPCODE_CHECK_EN
    localparam int FIFO_W = DATA_W + ADDR_W + 1;
`else
    localparam int FIFO_W = DATA_W + ADDR_W;
`endif
    localparam logic [CNT_W:0]    c_depth   = (CNT_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  c_cnt_one = CNT_W'(1);
    localparam logic [PTR_W-1:0]  c_ptr_one = PTR_W'(1);
    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);

    fetch_state_t      r_state;
    fetch_state_t      w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  w_out_after;
    logic [ADDR_W-1:0] r_pcq [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_pcq_wr;
    logic [PTR_W-1:0]  r_pcq_rd;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic [CNT_W:0]    w_credit_used;
    logic              w_grant;
    logic              w_push;
    logic              w_pop;
    logic [FIFO_W-1:0] w_push_data;
    logic [FIFO_W-1:0] w_pop_data;
    logic [1:0]        w_unused_redirect_lsb;

    assign w_unused_redirect_lsb = redirect_pc[1:0];

    // Buffered words plus in-flight requests may never exceed the FIFO depth.
    assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign imem_req  = (r_state == FETCH) && fetch_en && !redirect_valid &&
                       (w_credit_used < c_depth);
    assign imem_addr = r_pc;
    assign w_grant   = imem_req && imem_gnt;
    assign w_out_after = r_outstanding - (imem_rvalid ? c_cnt_one : '0);

    assign w_push = imem_rvalid && (r_state != FLUSH) && !redirect_valid;
    assign w_pop  = if_valid && if_ready;

`ifdef IFU_ILLEGAL_OPCODE_CHECK_EN
    assign w_push_data = {is_illegal(imem_rdata[31:0]), r_pcq[r_pcq_rd], imem_rdata};
    assign {if_illegal, if_pc, if_instr} = w_pop_data;
`else
    assign w_push_data = {r_pcq[r_pcq_rd], imem_rdata};
    assign {if_pc, if_instr} = w_pop_data;
`endif

    assign if_valid  = !w_fifo_empty;
    assign if_opcode = if_instr[31:26];
    assign if_funct  = if_instr[5:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (fetch_en) w_state_nxt = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    w_state_nxt = (w_out_after != '0) ? FLUSH : FETCH;
                end else if (!fetch_en && (r_outstanding == '0)) begin
                    w_state_nxt = IDLE;
                end
            end
            FLUSH: begin
                if (imem_rvalid && (r_outstanding == c_cnt_one)) begin
                    w_state_nxt = fetch_en ? FETCH : IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (redirect_valid) begin
                r_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else if (w_grant) begin
                r_pc <= r_pc + c_pc_step;
            end
            case ({w_grant, imem_rvalid})
                2'b10:   r_outstanding <= r_outstanding + c_cnt_one;
                2'b01:   r_outstanding <= r_outstanding - c_cnt_one;
                default: r_outstanding <= r_outstanding;
            endcase
            // Discarded responses still retire their PC-queue slot.
            if (w_grant)     r_pcq_wr <= r_pcq_wr + c_ptr_one;
            if (imem_rvalid) r_pcq_rd <= r_pcq_rd + c_ptr_one;
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_pcq[r_pcq_wr] <= r_pc;
        end
    end

    ifu_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .pop_data  (w_pop_data),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Randomised bench for instruction_fetch_unit against a queue-based
//            model of memory, instruction buffer and program-order PC.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

    localparam int          FIFO_DEPTH = 2;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [5:0]  if_opcode;
    logic [5:0]  if_funct;
`ifdef IFU_ILLEGAL_OPCODE_CHECK_EN
    logic        if_illegal;
`endif

    instruction_fetch_unit #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_opcode      (if_opcode),
        .if_funct       (if_funct)
`ifdef IFU_ILLEGAL_OPCODE_CHECK_EN
        ,
        .if_illegal     (if_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
        bit          stale;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] exp_req = RESET_PC;
    logic [31:0] cur_addr = '0;
    bit          cur_stale = 1'b0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n_deliv = 0;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0005;
            32'hFFFF_FFF8: return 32'hFC00_0000;
            32'hFFFF_FFFC: return 32'h0000_0020;
            default:       return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    function automatic bit ref_illegal(input logic [31:0] w);
        logic [5:0] op = w[31:26];
        logic [5:0] fn = w[5:0];
        if (op == 6'h00) return !(fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27});
        return !(op inside {6'h23, 6'h2B, 6'h04, 6'h08});
    endfunction

    // Called at the falling edge: compare outputs against the model, then advance it.
    task automatic observe();
        int stale_n;
        int outst;
        logic [31:0] w;
        check_value("if_valid", 32'(if_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            w = mem_fn(exp_q[0]);
            check_value("if_pc", if_pc, exp_q[0]);
            check_value("if_instr", if_instr, w);
            check_value("if_opcode", {26'b0, if_opcode}, w >> 26);
            check_value("if_funct", {26'b0, if_funct}, w & 32'h3F);
`ifdef IFU_ILLEGAL_OPCODE_CHECK_EN
            check_value("if_illegal", 32'(if_illegal), 32'(ref_illegal(w)));
`endif
            if (if_ready) begin
                void'(exp_q.pop_front());
                n_deliv++;
            end
        end
        stale_n = (imem_rvalid && cur_stale) ? 1 : 0;
        foreach (mem_q[i]) if (mem_q[i].stale) stale_n++;
        outst = mem_q.size() + (imem_rvalid ? 1 : 0);
        if (imem_req) begin
            check_value("req_gate", {29'b0, fetch_en, redirect_valid, stale_n == 0}, 32'b101);
            check_value("req_credit", 32'(exp_q.size() + outst < FIFO_DEPTH), 32'd1);
            if (imem_gnt) begin
                check_value("req_addr", imem_addr, exp_req);
                mem_q.push_back('{addr: imem_addr, due: cyc + lat, stale: 1'b0});
                exp_req += 32'd4;
            end
        end
        if (imem_rvalid && !cur_stale && !redirect_valid) exp_q.push_back(cur_addr);
        if (redirect_valid) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_req = {redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic run_cycle(input bit fe, input bit gnt, input bit rdy,
                             input bit rv, input logic [31:0] rpc);
        mreq_t m;
        @(posedge clk);
        cyc++;
        #1;
        imem_rvalid = 1'b0;
        cur_stale   = 1'b0;
        imem_rdata  = $urandom;
        if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            imem_rvalid = 1'b1;
            imem_rdata  = mem_fn(m.addr);
            cur_addr    = m.addr;
            cur_stale   = m.stale;
        end
        fetch_en       = fe;
        imem_gnt       = gnt;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        if (rst_n) observe();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_req"},    32'(imem_req), 32'd0);
        check_value({tag, "_addr"},   imem_addr, RESET_PC);
        check_value({tag, "_valid"},  32'(if_valid), 32'd0);
        check_value({tag, "_instr"},  if_instr, 32'd0);
        check_value({tag, "_pc"},     if_pc, 32'd0);
        check_value({tag, "_fields"}, {20'b0, if_opcode, if_funct}, 32'd0);
    endtask

    initial begin
        int  start;
        bit  found;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Streaming with a single-cycle memory.
        lat = 1;
        start = n_deliv;
        repeat (12) run_cycle(1, 1, 1, 0, '0);
        check_value("stream_progress", 32'(n_deliv - start >= 4), 32'd1);

        // Decode stall: buffer fills and requests stop.
        repeat (5) run_cycle(1, 1, 0, 0, '0);
        check_value("stall_req_drop", 32'(imem_req), 32'd0);
        check_value("stall_full", 32'(exp_q.size()), FIFO_DEPTH);
        start = n_deliv;
        repeat (6) run_cycle(1, 1, 1, 0, '0);
        check_value("stall_release", 32'(n_deliv - start >= 2), 32'd1);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            run_cycle(1, 1, 1, 0, '0);
            if (mem_q.size() == 2) found = 1'b1;
        end
        check_value("flush_setup", 32'(found), 32'd1);
        run_cycle(1, 1, 1, 1, 32'h0000_0103);
        start = n_deliv;
        repeat (14) run_cycle(1, 1, 1, 0, '0);
        check_value("flush_resume", 32'(n_deliv - start >= 2), 32'd1);

        // Redirect coinciding with a response and a pop, landing near the PC wrap.
        lat = 1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            run_cycle(1, 1, 1, 0, '0);
            if (mem_q.size() > 0 && mem_q[0].due == cyc + 1 && !mem_q[0].stale &&
                exp_q.size() > 0) found = 1'b1;
        end
        check_value("coincide_setup", 32'(found), 32'd1);
        run_cycle(1, 1, 1, 1, 32'hFFFF_FFF8);
        check_value("coincide_flush", 32'(imem_rvalid && !redirect_valid), 32'd0);
        start = n_deliv;
        repeat (12) run_cycle(1, 1, 1, 0, '0);
        check_value("wrap_progress", 32'(n_deliv - start >= 3), 32'd1);

        // Random traffic.
        start = n_deliv;
        for (int i = 0; i < 800; i++) begin
            lat = $urandom_range(1, 4);
            run_cycle(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7),
                      ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0),
                      ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                  : $urandom);
        end
        check_value("random_progress", 32'(n_deliv - start > 50), 32'd1);

        // Asynchronous reset with the buffer full.
        lat = 1;
        repeat (8) run_cycle(1, 1, 0, 0, '0);
        check_value("pre_reset_full", 32'(exp_q.size()), FIFO_DEPTH);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        mem_q.delete();
        exp_q.delete();
        exp_req        = RESET_PC;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        start = n_deliv;
        repeat (10) run_cycle(1, 1, 1, 0, '0);
        check_value("post_reset_progress", 32'(n_deliv - start >= 3), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage directly upstream of the decode/control stage.
- Owns the PC, issues word requests to instruction memory and buffers returned words in a small in-order FIFO.
- Presents instruction, PC and pre-split opcode/funct fields to decode over a valid/ready handshake.
- Accepts redirects from branch resolution (BEQ taken) and flushes wrong-path words.

Parameters:
- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction width.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- fetch_en  in  1  allow new requests; 0 idles the fetch stage.
- imem_req  out  1  request valid.
- imem_addr  out  ADDR_W  word-aligned request address.
- imem_gnt  in  1  request accepted when imem_req && imem_gnt.
- imem_rvalid  in  1  response valid; in order, latency at least 1 cycle.
- imem_rdata  in  DATA_W  response word.
- redirect_valid  in  1  branch taken, one-cycle pulse.
- redirect_pc  in  ADDR_W  target address; bits [1:0] ignored.
- if_valid  out  1  instruction available to decode.
- if_ready  in  1  decode accepts.
- if_instr  out  DATA_W  instruction word.
- if_pc  out  ADDR_W  address of if_instr.
- if_opcode  out  6  if_instr[31:26].
- if_funct  out  6  if_instr[5:0].

Behaviour:
- Reset (async assert, sync-released):
  - pc = RESET_PC, FIFO empty, outstanding = 0, state = IDLE.
  - All outputs 0, except imem_addr = RESET_PC.
- FSM states: IDLE, FETCH, FLUSH.
  - IDLE -> FETCH when fetch_en = 1.
  - FETCH -> IDLE when fetch_en = 0 and outstanding = 0; otherwise stay in FETCH with no new requests.
  - FETCH -> FLUSH on redirect_valid when outstanding, after this cycle's grants and responses, is nonzero.
  - FETCH -> FETCH on redirect_valid when that count is zero.
  - FLUSH -> FETCH (or IDLE if fetch_en = 0) when the last discarded response returns.
- Request issue:
  - imem_req = 1 in FETCH when fetch_en = 1, no redirect this cycle, and fifo_count + outstanding < FIFO_DEPTH.
  - imem_addr = pc (combinational from the register).
  - On grant: pc <= pc + 4; outstanding increments.
  - pc wraps 0xFFFF_FFFC -> 0x0000_0000.
- Response:
  - imem_rvalid pushes {pc_of_request, rdata} into the FIFO.
  - The request PC is tracked by a per-entry PC queue of FIFO_DEPTH entries.
  - if_valid rises the cycle after the rvalid; no combinational rdata-to-if_instr path.
  - Overflow cannot occur by the credit rule.
- Handshake:
  - if_instr, if_pc and if_valid are held stable while if_valid && !if_ready.
  - Pop on if_valid && if_ready.
  - Simultaneous push and pop are both honoured; a full FIFO popping accepts the push.
- Redirect (highest priority):
  - Same cycle: FIFO cleared, if_valid 0 next cycle, pc <= {redirect_pc[ADDR_W-1:2], 2'b00}.
  - A response arriving in the redirect cycle is discarded.
  - In FLUSH, every returning response is discarded and no requests are issued.
  - A redirect while in FLUSH reloads pc only; flush continues.
- Reset mid-operation: immediate return to reset values; in-flight memory responses after release are the memory's responsibility (the memory is reset by the same rst_n).

Optional Feature:
- Macro: IFU_ILLEGAL_OPCODE_CHECK_EN.
- Defined:
  - Adds output if_illegal (1 bit), valid with if_valid.
  - if_illegal is set when if_opcode is not one of R-type 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000.
  - It is also set for R-type with funct not in {100000, 100010, 100100, 100101, 100110, 100111}.
  - Computed at FIFO push and stored per entry.
  - Reset value 0.
- Not defined: port absent, no extra storage.

Decomposition:
- Package cpu_isa_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI;
  - funct constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR;
  - typedef fetch_state_t {IDLE, FETCH, FLUSH}.
- The package is shared with the control unit.
- One sub-module, ifu_fifo: parameterised sync FIFO with flush input and width DATA_W + ADDR_W (+1 with the optional feature).

Test Plan:
- Reset release, fetch_en = 1, 1-cycle memory with gnt = 1: imem_addr goes 0x0, 0x4, 0x8.
  - if_pc = 0x0 with instr 0x2008_0005 (ADDI) one cycle after the first rvalid.
  - Then one instruction per cycle while if_ready = 1.
- Hold if_ready = 0 for 5 cycles: FIFO fills to 2, imem_req drops, if_instr and if_pc stay stable.
  - Releasing delivers 0x4 and 0x8 in order with no loss.
- Redirect to 0x103 with 2 outstanding, 3-cycle latency: FSM enters FLUSH and both responses are discarded.
  - The next request addresses 0x100; next if_pc = 0x100.
- Redirect in the same cycle as rvalid and an if_valid/if_ready pop: the response is dropped, if_valid = 0 next cycle, pc = target.
- Set pc near the wrap point (redirect to 0xFFFF_FFF8): addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - With IFU_ILLEGAL_OPCODE_CHECK_EN, instr 0xFC00_0000 gives if_illegal = 1; 0x0000_0020 gives 0.
- Assert rst_n = 0 mid-fetch with FIFO full: outputs go to reset values immediately (asynchronously).
  - The first request after release addresses RESET_PC.
